// File: rtl/cuppa_wvb_acq_ctrl_if.sv
// Signal bundle between the ADC/configuration side and the waveform acquisition controller.
// The master side drives configuration and samples; the slave (controller) drives the write port.
interface cuppa_wvb_acq_ctrl_if;
  logic [53:0] wvb_conf_bundle;
  logic [13:0] adc_data;
  logic        thresh_tot;
  logic        buf_full;
  logic [13:0] wvb_data;
  logic        wvb_wr_en;
  logic        wvb_trig;
  logic        wvb_eoe;
  logic [1:0]  trig_src;
  logic        armed;
  logic        ovfl;
  logic [15:0] evt_cnt;

  modport master (
    output wvb_conf_bundle, adc_data, thresh_tot, buf_full,
    input  wvb_data, wvb_wr_en, wvb_trig, wvb_eoe, trig_src, armed, ovfl, evt_cnt
  );

  modport slave (
    input  wvb_conf_bundle, adc_data, thresh_tot, buf_full,
    output wvb_data, wvb_wr_en, wvb_trig, wvb_eoe, trig_src, armed, ovfl, evt_cnt
  );
endinterface

// File: rtl/cuppa_wvb_acq_ctrl.sv
// Single-channel waveform acquisition: pre-trigger history ring, trigger selection and
// gated write strobes with trigger/end-of-event markers toward the waveform buffer.
//
// state   | meaning
// IDLE    | not armed, counters held at zero
// FILL    | collecting pre_len samples of history after arming or after an event
// WAIT    | accepting threshold/test/constant triggers
// CAPTURE | strobing the pre_len + post_len + 1 sample event window
module cuppa_wvb_acq_ctrl (
  input  logic                       clk,
  input  logic                       rst,
  cuppa_wvb_acq_ctrl_if.slave        acq
);

  typedef enum logic [1:0] {IDLE, FILL, WAIT, CAPTURE} state_t;

  state_t      state;

  logic [14:0] cnst_conf;
  logic [14:0] test_conf;
  logic [14:0] post_conf;
  logic [5:0]  pre_conf;
  logic        arm;
  logic        trig_mode;
  logic        cnst_run;

  assign cnst_conf = acq.wvb_conf_bundle[14:0];
  assign test_conf = acq.wvb_conf_bundle[29:15];
  assign post_conf = acq.wvb_conf_bundle[44:30];
  assign pre_conf  = acq.wvb_conf_bundle[50:45];
  assign arm       = acq.wvb_conf_bundle[51];
  assign trig_mode = acq.wvb_conf_bundle[52];
  assign cnst_run  = acq.wvb_conf_bundle[53];

  logic [13:0] ring [64];
  logic [5:0]  wr_ptr;
  logic [5:0]  pre_len;
  logic [14:0] post_len;
  logic [15:0] cap_cnt;
  logic [5:0]  fill_cnt;
  logic [14:0] test_cnt;
  logic [14:0] cnst_cnt;
  logic        thresh_tot_q;

  logic [13:0] wvb_data_r;
  logic        wr_en_r;
  logic        trig_r;
  logic        eoe_r;
  logic [1:0]  trig_src_r;
  logic        armed_r;
  logic        ovfl_r;
  logic [15:0] evt_cnt_r;

  logic        thr_fire;
  logic        test_fire;
  logic        cnst_fire;
  logic        mode_fire;
  logic        any_fire;
  logic [15:0] window_m1;
  logic [5:0]  fill_load_arm;
  logic [5:0]  fill_load_evt;

  assign thr_fire  = ~trig_mode & acq.thresh_tot & ~thresh_tot_q;
  assign test_fire = trig_mode & (test_conf != 15'd0) & (test_cnt == test_conf - 15'd1);
  assign cnst_fire = cnst_run & (cnst_conf != 15'd0) & (cnst_cnt == cnst_conf - 15'd1);
  assign mode_fire = thr_fire | test_fire;
  assign any_fire  = mode_fire | cnst_fire;

  // Window length minus one; the capture down-counter terminates at zero on the eoe sample.
  assign window_m1     = {10'd0, pre_len} + {1'b0, post_conf};
  assign fill_load_arm = (pre_conf == 6'd0) ? 6'd0 : pre_conf - 6'd1;
  assign fill_load_evt = (pre_len == 6'd0) ? 6'd0 : pre_len - 6'd1;

  always_ff @(posedge clk) begin
    ring[wr_ptr] <= acq.adc_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= 6'd0;
      pre_len      <= 6'd0;
      post_len     <= 15'd0;
      cap_cnt      <= 16'd0;
      fill_cnt     <= 6'd0;
      test_cnt     <= 15'd0;
      cnst_cnt     <= 15'd0;
      thresh_tot_q <= 1'b0;
      wvb_data_r   <= 14'd0;
      wr_en_r      <= 1'b0;
      trig_r       <= 1'b0;
      eoe_r        <= 1'b0;
      trig_src_r   <= 2'b00;
      armed_r      <= 1'b0;
      ovfl_r       <= 1'b0;
      evt_cnt_r    <= 16'd0;
    end else begin
      wr_ptr       <= wr_ptr + 6'd1;
      thresh_tot_q <= acq.thresh_tot;
      // pre_len == 0 needs the sample being written this very cycle, which the ring cannot supply yet.
      wvb_data_r   <= (pre_len == 6'd0) ? acq.adc_data : ring[wr_ptr - pre_len];
      ovfl_r       <= 1'b0;

      if (state == IDLE) begin
        test_cnt <= 15'd0;
        cnst_cnt <= 15'd0;
      end else begin
        test_cnt <= ((test_conf == 15'd0) || (test_cnt >= test_conf - 15'd1)) ? 15'd0 : test_cnt + 15'd1;
        cnst_cnt <= ((cnst_conf == 15'd0) || (cnst_cnt >= cnst_conf - 15'd1)) ? 15'd0 : cnst_cnt + 15'd1;
      end

      case (state)
        IDLE: begin
          if (arm) begin
            state    <= FILL;
            armed_r  <= 1'b1;
            pre_len  <= pre_conf;
            fill_cnt <= fill_load_arm;
          end
        end
        FILL: begin
          if (!arm) begin
            state   <= IDLE;
            armed_r <= 1'b0;
          end else if (fill_cnt == 6'd0) begin
            state <= WAIT;
          end else begin
            fill_cnt <= fill_cnt - 6'd1;
          end
        end
        WAIT: begin
          if (!arm) begin
            state   <= IDLE;
            armed_r <= 1'b0;
          end else if (any_fire) begin
            if (acq.buf_full) begin
              ovfl_r <= 1'b1;
            end else begin
              state      <= CAPTURE;
              post_len   <= post_conf;
              cap_cnt    <= window_m1;
              wr_en_r    <= 1'b1;
              trig_r     <= (pre_len == 6'd0);
              eoe_r      <= (window_m1 == 16'd0);
              trig_src_r <= mode_fire ? {trig_mode, ~trig_mode} : 2'b11;
              evt_cnt_r  <= evt_cnt_r + 16'd1;
            end
          end
        end
        CAPTURE: begin
          if (cap_cnt == 16'd0) begin
            wr_en_r  <= 1'b0;
            trig_r   <= 1'b0;
            eoe_r    <= 1'b0;
            fill_cnt <= fill_load_evt;
            if (arm) begin
              state <= FILL;
            end else begin
              state   <= IDLE;
              armed_r <= 1'b0;
            end
          end else begin
            cap_cnt <= cap_cnt - 16'd1;
            trig_r  <= ((cap_cnt - 16'd1) == {1'b0, post_len});
            eoe_r   <= (cap_cnt == 16'd1);
          end
        end
        default: begin
          state   <= IDLE;
          armed_r <= 1'b0;
        end
      endcase
    end
  end

  assign acq.wvb_data  = wvb_data_r;
  assign acq.wvb_wr_en = wr_en_r;
  assign acq.wvb_trig  = trig_r;
  assign acq.wvb_eoe   = eoe_r;
  assign acq.trig_src  = trig_src_r;
  assign acq.armed     = armed_r;
  assign acq.ovfl      = ovfl_r;
  assign acq.evt_cnt   = evt_cnt_r;

endmodule

// File: tb/tb_cuppa_wvb_acq_ctrl.sv
// Bench for cuppa_wvb_acq_ctrl: scenario table, hand-written corner sequences and a
// randomized run against a timestamp-based event model.
module tb_cuppa_wvb_acq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cuppa_wvb_acq_ctrl_if acq ();
  cuppa_wvb_acq_ctrl dut (.clk(clk), .rst(rst), .acq(acq));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [53:0] mk(bit arm, bit mode, bit crun, int pre, int post, int tconf, int cconf);
    logic [5:0]  p;
    logic [14:0] po, tc, cc;
    p  = pre[5:0];
    po = post[14:0];
    tc = tconf[14:0];
    cc = cconf[14:0];
    return {crun, mode, arm, p, po, tc, cc};
  endfunction

  task automatic drive(logic [53:0] b, int adc, bit thr, bit bf);
    acq.wvb_conf_bundle = b;
    acq.adc_data        = adc[13:0];
    acq.thresh_tot      = thr;
    acq.buf_full        = bf;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(54'd0, 0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_rst_armed"}, int'(acq.armed), 0);
    chk({tag, "_rst_wr_en"}, int'(acq.wvb_wr_en), 0);
    chk({tag, "_rst_evt"}, int'(acq.evt_cnt), 0);
    chk({tag, "_rst_src"}, int'(acq.trig_src), 0);
    chk({tag, "_rst_ovfl"}, int'(acq.ovfl), 0);
    chk({tag, "_rst_data"}, int'(acq.wvb_data), 0);
  endtask

  // Observation of the write port
  int strobes, ovfl_n;
  bit in_evt;
  int first_q[$], trig_q[$], eoe_q[$];

  task automatic clear_obs();
    strobes = 0; ovfl_n = 0; in_evt = 1'b0;
    first_q.delete(); trig_q.delete(); eoe_q.delete();
  endtask

  task automatic obs();
    if (acq.wvb_wr_en) begin
      strobes++;
      if (!in_evt) begin
        first_q.push_back(int'(acq.wvb_data));
        in_evt = 1'b1;
      end
      if (acq.wvb_trig) trig_q.push_back(int'(acq.wvb_data));
      if (acq.wvb_eoe) begin
        eoe_q.push_back(int'(acq.wvb_data));
        in_evt = 1'b0;
      end
    end
    if (acq.ovfl) ovfl_n++;
  endtask

  function automatic int q0(int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  typedef struct {
    int pre, post, mode, tconf, crun, cconf, thr_at, bf;
    int e_strobes, e_first, e_trig, e_eoe, e_src, e_evt, e_ovfl;
  } vec_t;

  // Randomized-phase model state (event timestamps rather than a state machine)
  int  samp [20000];
  bit  e_wr [20000];
  bit  e_trig [20000];
  bit  e_eoe [20000];
  int  e_idx [20000];
  int  t;
  bit  m_arm, m_thr_prev, r_thr;
  int  arm_start, wait_start, cap_end, m_pre, m_post, m_evt, m_src;
  int  cfg_pre, cfg_post_max, cfg_tconf, cfg_cconf;
  bit  cfg_mode, cfg_crun;

  task automatic rstep(bit arm_i);
    bit thr_i, bf_i, idle, cap, wt, tf, cf, thr_rise, mode_f, c_f, n_ovfl;
    int adc_i, pre_i, post_i, el, len;
    thr_i  = ($urandom_range(0, 7) == 0) ? ~r_thr : r_thr;
    r_thr  = thr_i;
    bf_i   = ($urandom_range(0, 9) == 0);
    adc_i  = int'($urandom & 32'h3fff);
    pre_i  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : cfg_pre;
    post_i = int'($urandom_range(0, cfg_post_max));
    samp[t] = adc_i;

    idle = !m_arm;
    cap  = m_arm && (t <= cap_end);
    wt   = m_arm && !cap && (t >= wait_start);
    el   = t - arm_start;
    tf   = m_arm && (cfg_tconf != 0) && ((el % cfg_tconf) == cfg_tconf - 1);
    cf   = m_arm && (cfg_cconf != 0) && ((el % cfg_cconf) == cfg_cconf - 1);
    thr_rise   = thr_i && !m_thr_prev;
    m_thr_prev = thr_i;
    mode_f = cfg_mode ? tf : thr_rise;
    c_f    = cfg_crun && cf;
    n_ovfl = 1'b0;

    if (idle) begin
      if (arm_i) begin
        m_arm      = 1'b1;
        m_pre      = pre_i;
        arm_start  = t + 1;
        wait_start = t + 1 + ((m_pre == 0) ? 1 : m_pre);
        cap_end    = -1;
      end
    end else if (cap) begin
      if (t == cap_end && !arm_i) m_arm = 1'b0;
    end else if (!arm_i) begin
      m_arm = 1'b0;
    end else if (wt && (mode_f || c_f)) begin
      if (bf_i) begin
        n_ovfl = 1'b1;
      end else begin
        m_post = post_i;
        len    = m_pre + m_post + 1;
        for (int i = 0; i < len; i++) begin
          e_wr[t + 1 + i]   = 1'b1;
          e_idx[t + 1 + i]  = t - m_pre + i;
          e_trig[t + 1 + i] = (i == m_pre);
          e_eoe[t + 1 + i]  = (i == len - 1);
        end
        cap_end    = t + len;
        wait_start = t + len + 1 + ((m_pre == 0) ? 1 : m_pre);
        m_evt      = (m_evt + 1) & 16'hffff;
        m_src      = mode_f ? (cfg_mode ? 2 : 1) : 3;
      end
    end

    drive(mk(arm_i, cfg_mode, cfg_crun, pre_i, post_i, cfg_tconf, cfg_cconf), adc_i, thr_i, bf_i);
    tick();
    t++;
    chk("rnd_wr_en", int'(acq.wvb_wr_en), int'(e_wr[t]));
    chk("rnd_trig", int'(acq.wvb_trig), int'(e_trig[t]));
    chk("rnd_eoe", int'(acq.wvb_eoe), int'(e_eoe[t]));
    if (e_wr[t]) chk("rnd_data", int'(acq.wvb_data), samp[e_idx[t]]);
    chk("rnd_armed", int'(acq.armed), int'(m_arm));
    chk("rnd_ovfl", int'(acq.ovfl), int'(n_ovfl));
    chk("rnd_evt", int'(acq.evt_cnt), m_evt);
    chk("rnd_src", int'(acq.trig_src), m_src);
  endtask

  initial begin
    vec_t vt [9];
    bit thr, bf, arm;
    int pre_f, bound;

    rst = 1'b1;
    drive(54'd0, 0, 1'b0, 1'b0);

    //          pre post md tcf cr ccf thr bf | strb first trig eoe src evt ovfl
    vt[0] = '{4,  10,  0, 0,  0, 0,   100, 0,  15,  96,  100, 110, 1, 1, 0};
    vt[1] = '{0,  0,   0, 0,  0, 0,   100, 0,  1,   100, 100, 100, 1, 1, 0};
    vt[2] = '{63, 5,   0, 0,  0, 0,   150, 0,  69,  87,  150, 155, 1, 1, 0};
    vt[3] = '{63, 5,   0, 0,  0, 0,   30,  0,  0,   -1,  -1,  -1,  0, 0, 0};
    vt[4] = '{4,  10,  0, 0,  0, 0,   100, 1,  0,   -1,  -1,  -1,  0, 0, 1};
    vt[5] = '{2,  3,   0, 0,  1, 150, -1,  0,  6,   148, 150, 153, 3, 1, 0};
    vt[6] = '{0,  0,   1, 60, 0, 0,   -1,  0,  3,   60,  60,  60,  2, 3, 0};
    vt[7] = '{1,  100, 0, 0,  1, 99,  99,  0,  102, 98,  99,  199, 1, 1, 0};
    vt[8] = '{0,  0,   1, 0,  0, 0,   50,  0,  0,   -1,  -1,  -1,  0, 0, 0};

    for (int r = 0; r < 9; r++) begin
      do_reset();
      chk_reset_state($sformatf("row%0d", r));
      clear_obs();
      for (int k = 0; k < 240; k++) begin
        thr = (vt[r].thr_at >= 0) && (k >= vt[r].thr_at);
        drive(mk(1'b1, vt[r].mode[0], vt[r].crun[0], vt[r].pre, vt[r].post, vt[r].tconf, vt[r].cconf),
              k, thr, vt[r].bf[0]);
        tick();
        obs();
      end
      chk($sformatf("row%0d_strobes", r), strobes, vt[r].e_strobes);
      chk($sformatf("row%0d_first", r), q0(first_q), vt[r].e_first);
      chk($sformatf("row%0d_trig", r), q0(trig_q), vt[r].e_trig);
      chk($sformatf("row%0d_eoe", r), q0(eoe_q), vt[r].e_eoe);
      chk($sformatf("row%0d_src", r), int'(acq.trig_src), vt[r].e_src);
      chk($sformatf("row%0d_evt", r), int'(acq.evt_cnt), vt[r].e_evt);
      chk($sformatf("row%0d_ovfl", r), ovfl_n, vt[r].e_ovfl);
    end

    // buf_full at the first trigger, then a normal event once it clears
    do_reset();
    clear_obs();
    for (int k = 0; k < 120; k++) begin
      thr = ((k >= 50) && (k < 60)) || (k >= 80);
      bf  = (k < 60);
      drive(mk(1'b1, 1'b0, 1'b0, 2, 2, 0, 0), k, thr, bf);
      tick();
      obs();
      if (k == 50) begin
        chk("bf_ovfl_pulse", int'(acq.ovfl), 1);
        chk("bf_evt_hold", int'(acq.evt_cnt), 0);
      end
    end
    chk("bf_ovfl_count", ovfl_n, 1);
    chk("bf_strobes", strobes, 5);
    chk("bf_first", q0(first_q), 78);
    chk("bf_trig", q0(trig_q), 80);
    chk("bf_evt", int'(acq.evt_cnt), 1);

    // arm dropped mid-capture, then re-arm with a 63-sample pre-window
    do_reset();
    clear_obs();
    for (int k = 0; k < 240; k++) begin
      arm   = (k < 60) || (k >= 80);
      pre_f = (k < 62) ? 4 : 63;
      thr   = ((k >= 50) && (k < 78)) || (k == 143) || (k >= 145);
      drive(mk(arm, 1'b0, 1'b0, pre_f, 20, 0, 0), k, thr, 1'b0);
      tick();
      obs();
      if (k == 74) begin
        chk("drop_eoe_cycle", int'(acq.wvb_eoe), 1);
        chk("drop_armed_at_eoe", int'(acq.armed), 1);
      end
      if (k == 75) chk("drop_armed_after", int'(acq.armed), 0);
      if (k == 144) chk("rearm_fill_ignores", int'(acq.evt_cnt), 1);
    end
    chk("drop_strobes", strobes, 109);
    chk("drop_n_events", eoe_q.size(), 2);
    if (eoe_q.size() == 2) begin
      chk("drop_eoe1", eoe_q[0], 70);
      chk("rearm_first", first_q[1], 82);
      chk("rearm_trig", trig_q[1], 145);
      chk("rearm_eoe", eoe_q[1], 165);
    end
    chk("rearm_evt", int'(acq.evt_cnt), 2);

    // synchronous reset in the middle of a capture window
    do_reset();
    clear_obs();
    for (int k = 0; k < 55; k++) begin
      drive(mk(1'b1, 1'b0, 1'b0, 4, 10, 0, 0), k, (k >= 50), 1'b0);
      tick();
      obs();
    end
    chk("midrst_pre_wr_en", int'(acq.wvb_wr_en), 1);
    rst = 1'b1;
    drive(mk(1'b1, 1'b0, 1'b0, 4, 10, 0, 0), 55, 1'b1, 1'b0);
    tick();
    chk("midrst_eoe", int'(acq.wvb_eoe), 0);
    chk("midrst_trig", int'(acq.wvb_trig), 0);
    chk_reset_state("midrst");
    rst = 1'b0;
    for (int k = 56; k < 76; k++) begin
      drive(mk(1'b0, 1'b0, 1'b0, 4, 10, 0, 0), k, 1'b1, 1'b0);
      tick();
      obs();
    end
    chk("midrst_strobes", strobes, 5);
    chk("midrst_no_eoe", eoe_q.size(), 0);

    // randomized run against the event model
    do_reset();
    t = 0; m_arm = 1'b0; m_thr_prev = 1'b0; r_thr = 1'b0;
    arm_start = 0; wait_start = 0; cap_end = -1; m_pre = 0; m_post = 0; m_evt = 0; m_src = 0;
    cfg_pre = 0; cfg_post_max = 0; cfg_tconf = 0; cfg_cconf = 0; cfg_mode = 1'b0; cfg_crun = 1'b0;
    for (int seg = 0; seg < 20 && t < 18000; seg++) begin
      bound = 0;
      while (m_arm && bound < 300) begin
        rstep(1'b0);
        bound++;
      end
      chk("rnd_disarm_bound", int'(m_arm), 0);
      cfg_pre      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6));
      cfg_post_max = int'($urandom_range(0, 20));
      cfg_mode     = $urandom_range(0, 1) == 1;
      cfg_crun     = $urandom_range(0, 1) == 1;
      cfg_tconf    = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(3, 60));
      cfg_cconf    = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(3, 80));
      for (int i = 0; i < int'($urandom_range(150, 400)); i++) begin
        rstep($urandom_range(0, 199) != 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
